pool2x2_max: RTL and testbench

Two-by-two, stride-2 max-pooling stage placed directly downstream of the conv1 block in the LeNet pipeline. It consumes the conv1 activation stream: one pixel position per valid beat, all feature maps in parallel, raster order over a 28x28 map. It produces one pooled pixel of the 14x14 output per ready pulse, in the same lane packing. It buffers one half-row of partial maxima so the stream is reduced in a single pass, with no backpressure.

---
 rtl/pool2x2_max.sv | 182 ++++++++++++++++++
 tb/tb_pool2x2_max.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool2x2_max.sv
// -----------------------------------------------------------------------------
// pool2x2_max
//
// Two-by-two, stride-2 max-pooling stage for the conv1 activation stream.
// Pixels arrive one per valid beat in raster order, with every feature map
// packed side by side in one word. Each pooled pixel is produced in a single
// pass. A horizontal hold register pairs neighbouring columns, and a half-row
// line buffer pairs neighbouring rows. There is no backpressure: downstream
// logic must accept every ready pulse.
//
// Parameters
//   BITWIDTH  width of one signed activation lane
//   NFMAPS    number of lanes; lane k is bits [k*BITWIDTH +: BITWIDTH]
//   IN_W      input map width in pixels (even, >= 4)
//   IN_H      input map height in pixels (even)
//
// Ports
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   valid       input_act carries the next raster-order pixel
//   flush       synchronous frame abort; a valid beat in the same cycle is dropped
//   input_act   packed conv1 activations (NFMAPS*BITWIDTH)
//   output_act  packed pooled activations, registered; held between pulses
//   ready       one-cycle pulse when output_act holds a new pooled pixel
// -----------------------------------------------------------------------------
module pool2x2_max #(
  parameter int BITWIDTH = 16,
  parameter int NFMAPS   = 6,
  parameter int IN_W     = 28,
  parameter int IN_H     = 28
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       valid,
  input  logic                       flush,
  input  logic [NFMAPS*BITWIDTH-1:0] input_act,
  output logic [NFMAPS*BITWIDTH-1:0] output_act,
  output logic                       ready
);

  localparam int DW       = NFMAPS * BITWIDTH;
  localparam int CW       = $clog2(IN_W);
  localparam int RW       = $clog2(IN_H);
  localparam int LB_DEPTH = IN_W / 2;
  localparam int LBW      = (CW > 1) ? CW - 1 : 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [DW-1:0] h_q, h_d;
  logic [DW-1:0] out_q, out_d;
  logic          ready_q, ready_d;

  // One partial maximum per horizontal pair in the current even row. It is
  // written on even rows and read on odd rows, so the same entry is never read
  // and written in the same cycle. The array is not reset because every entry
  // is written before it is read.
  logic [DW-1:0] linebuf_mem [LB_DEPTH];
  logic          lb_we;
  logic [LBW-1:0] lb_idx;
  logic [DW-1:0] lb_rd;

  // ---------------------------------------------------------------------------
  // Position decode
  // ---------------------------------------------------------------------------
  logic col_last;
  logic row_last;
  logic col_odd;
  logic row_odd;

  assign col_last = (col_q == CW'(IN_W - 1));
  assign row_last = (row_q == RW'(IN_H - 1));
  assign col_odd  = col_q[0];
  assign row_odd  = row_q[0];

  // Both columns of a pair map to the same line-buffer slot.
  assign lb_idx = LBW'(col_q >> 1);
  assign lb_rd  = linebuf_mem[lb_idx];

  // ---------------------------------------------------------------------------
  // Per-lane signed compare trees
  //   m_all    : max(h, input_act)   -- horizontal pair maximum
  //   pool_all : max(linebuf, m_all) -- full 2x2 block maximum
  // On a tie the first operand wins. The results are identical either way,
  // but this keeps the selection deterministic.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] m_all;
  logic [DW-1:0] pool_all;

  genvar gi;
  generate
    for (gi = 0; gi < NFMAPS; gi++) begin : g_lane
      logic signed [BITWIDTH-1:0] h_l;
      logic signed [BITWIDTH-1:0] in_l;
      logic signed [BITWIDTH-1:0] lb_l;
      logic signed [BITWIDTH-1:0] m_l;
      logic signed [BITWIDTH-1:0] p_l;

      assign h_l  = h_q[gi*BITWIDTH +: BITWIDTH];
      assign in_l = input_act[gi*BITWIDTH +: BITWIDTH];
      assign lb_l = lb_rd[gi*BITWIDTH +: BITWIDTH];

      assign m_l = (h_l >= in_l) ? h_l : in_l;
      assign p_l = (lb_l >= m_l) ? lb_l : m_l;

      assign m_all[gi*BITWIDTH +: BITWIDTH]    = m_l;
      assign pool_all[gi*BITWIDTH +: BITWIDTH] = p_l;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    h_d     = h_q;
    out_d   = out_q;
    ready_d = 1'b0;   // ready is a single-cycle pulse
    lb_we   = 1'b0;

    if (flush) begin
      // Return to the frame start. Any beat in this cycle is discarded.
      // The hold register, line buffer and output keep their contents.
      col_d = '0;
      row_d = '0;
    end else if (valid) begin
      // Raster counters; the wrap at the last pixel lets frames run back to back.
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      if (!col_odd) begin
        // First pixel of a horizontal pair.
        h_d = input_act;
      end else if (!row_odd) begin
        // Top half of a block: park the pair maximum for the next row.
        lb_we = 1'b1;
      end else begin
        // Bottom-right pixel: the block is complete.
        out_d   = pool_all;
        ready_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q   <= '0;
      row_q   <= '0;
      h_q     <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      h_q     <= h_d;
      out_q   <= out_d;
      ready_q <= ready_d;
    end
  end

  // The line buffer is kept outside the reset domain so it can map onto
  // plain memory.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf_mem[lb_idx] <= m_all;
    end
  end

  assign output_act = out_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_pool2x2_max.sv
// -----------------------------------------------------------------------------
// tb_pool2x2_max
//
// Directed testbench for pool2x2_max with the default 6 x 16-bit, 28x28
// configuration. Each scenario task drives its own stimulus and checks the
// results inline against hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_pool2x2_max;

  localparam int BW = 16;
  localparam int NF = 6;
  localparam int W  = 28;
  localparam int H  = 28;
  localparam int DW = BW * NF;

  logic          clk = 1'b0;
  logic          rstn;
  logic          valid;
  logic          flush;
  logic [DW-1:0] input_act;
  logic [DW-1:0] output_act;
  logic          ready;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_out;   // value output_act must currently hold

  always #5 clk = ~clk;

  pool2x2_max #(
    .BITWIDTH(BW),
    .NFMAPS  (NF),
    .IN_W    (W),
    .IN_H    (H)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .valid     (valid),
    .flush     (flush),
    .input_act (input_act),
    .output_act(output_act),
    .ready     (ready)
  );

  // Drive one cycle of inputs. The task returns 1 time unit after the edge.
  task automatic beat(input logic v, input logic f, input logic [DW-1:0] d);
    valid     = v;
    flush     = f;
    input_act = d;
    @(posedge clk);
    #1;
  endtask

  // Ramp frame, or its first npix pixels. The maximum of each ramp block is
  // its bottom-right pixel, so each pulse must carry that pixel's index.
  task automatic run_ramp(input int npix, input int max_gap, input string tag);
    int            pulses;
    int            r;
    int            c;
    int            n;
    logic          exp_rdy;
    logic [BW-1:0] e;
    pulses = 0;
    for (int p = 0; p < npix; p++) begin
      r = p / W;
      c = p % W;
      beat(1'b1, 1'b0, {NF{BW'(p)}});
      exp_rdy = (r % 2 == 1) && (c % 2 == 1);
      checks++;
      if (ready !== exp_rdy) begin
        errors++;
        $display("FAIL %s_ready pix(%0d,%0d): got %b expected %b", tag, r, c, ready, exp_rdy);
      end
      if (exp_rdy) begin
        pulses++;
        e       = BW'(p);
        exp_out = {NF{e}};
        checks++;
        if (output_act !== exp_out) begin
          errors++;
          $display("FAIL %s_out pix(%0d,%0d): got %h expected %h", tag, r, c, output_act, exp_out);
        end
      end
      if (max_gap > 0) begin
        n     = $urandom_range(max_gap, 0);
        valid = 1'b0;
        for (int i = 0; i < n; i++) begin
          @(posedge clk);
          #1;
          checks++;
          if (ready !== 1'b0 || output_act !== exp_out) begin
            errors++;
            $display("FAIL %s_idle after pix(%0d,%0d): ready %b out %h expected ready 0 out %h",
                     tag, r, c, ready, output_act, exp_out);
          end
        end
      end
    end
    if (npix == W * H) begin
      checks++;
      if (pulses != 196) begin
        errors++;
        $display("FAIL %s_pulse_count: got %0d expected 196", tag, pulses);
      end
      checks++;
      if (output_act !== {NF{16'd783}}) begin
        errors++;
        $display("FAIL %s_last_out: got %h expected all lanes 783", tag, output_act);
      end
    end
  endtask

  // Pattern generator for the two-row block tests.
  //   mode 0: lane 0 block 0 = {-5,-3 / -7,-4}, lane 1 = 0x8000 everywhere
  //   mode 1: top-left of each block lane k = k*100, lane 5 = -500, else 0
  function automatic logic [DW-1:0] pix(input int mode, input int r, input int c);
    logic [DW-1:0] v;
    logic [BW-1:0] sv [4];
    v = '0;
    if (mode == 0) begin
      sv = '{16'hFFFB, 16'hFFFD, 16'hFFF9, 16'hFFFC};
      if (c < 2) v[BW-1:0] = sv[r*2+c];
      v[2*BW-1:BW] = 16'h8000;
    end else if (r % 2 == 0 && c % 2 == 0) begin
      for (int k = 0; k < 5; k++) v[k*BW +: BW] = BW'(k * 100);
      v[5*BW +: BW] = 16'hFE0C;
    end
    return v;
  endfunction

  // Feed the first two rows, check every pulse, then flush back to frame start.
  task automatic feed_two_rows(input int mode, input logic [DW-1:0] exp_first,
                               input logic [DW-1:0] exp_rest, input string tag);
    logic exp_rdy;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < W; c++) begin
        beat(1'b1, 1'b0, pix(mode, r, c));
        exp_rdy = (r == 1) && (c % 2 == 1);
        checks++;
        if (ready !== exp_rdy) begin
          errors++;
          $display("FAIL %s_ready pix(%0d,%0d): got %b expected %b", tag, r, c, ready, exp_rdy);
        end
        if (exp_rdy) begin
          exp_out = (c == 1) ? exp_first : exp_rest;
          checks++;
          if (output_act !== exp_out) begin
            errors++;
            $display("FAIL %s_out block %0d: got %h expected %h", tag, c / 2, output_act, exp_out);
          end
        end
      end
    end
    beat(1'b0, 1'b1, '0);
    checks++;
    if (ready !== 1'b0 || output_act !== exp_out) begin
      errors++;
      $display("FAIL %s_flush: ready %b out %h expected ready 0 out %h", tag, ready, output_act, exp_out);
    end
  endtask

  task automatic test_reset();
    rstn      = 1'b0;
    valid     = 1'b0;
    flush     = 1'b0;
    input_act = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (output_act !== '0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out %h ready %b expected 0 0", output_act, ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (output_act !== '0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: out %h ready %b expected 0 0", output_act, ready);
    end
    exp_out = '0;
  endtask

  task automatic test_ramp();
    run_ramp(W * H, 0, "ramp");
  endtask

  task automatic test_back_to_back();
    run_ramp(W * H, 0, "b2b_a");
    run_ramp(W * H, 0, "b2b_b");
  endtask

  task automatic test_sparse();
    run_ramp(W * H, 3, "sparse");
  endtask

  task automatic test_signed();
    feed_two_rows(0, {16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 16'hFFFD},
                     {16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 16'h0000}, "signed");
  endtask

  task automatic test_lanes();
    feed_two_rows(1, {16'd0, 16'd400, 16'd300, 16'd200, 16'd100, 16'd0},
                     {16'd0, 16'd400, 16'd300, 16'd200, 16'd100, 16'd0}, "lanes");
  endtask

  task automatic test_flush();
    run_ramp(100, 0, "pre_flush");
    beat(1'b1, 1'b1, {NF{16'h7FFF}});
    checks++;
    if (ready !== 1'b0 || output_act !== exp_out) begin
      errors++;
      $display("FAIL flush_cycle: ready %b out %h expected ready 0 out %h", ready, output_act, exp_out);
    end
    run_ramp(W * H, 0, "post_flush");
  endtask

  task automatic test_async_reset();
    run_ramp(15 * W + 9, 0, "pre_reset");
    valid = 1'b0;
    #1;
    rstn = 1'b0;
    #1;
    checks++;
    if (output_act !== '0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_immediate: out %h ready %b expected 0 0", output_act, ready);
    end
    exp_out = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (output_act !== '0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_held: out %h ready %b expected 0 0", output_act, ready);
    end
    rstn = 1'b1;
    run_ramp(W * H, 0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_back_to_back();
    test_sparse();
    test_signed();
    test_lanes();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
